// File: rtl/demoscene_pkg.sv
// Shared definitions for the demoscene frame engine.
//   - Default 640x480@60 VGA timing constants (pixel clock 25.175 MHz).
//   - Position counter width used by all timing logic.
//   - Scene sequencer state encoding (ST_PLAY / ST_HOLD).
//   - clog2 helper for sizing index and counter fields.
package demoscene_pkg;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  // hpos/vpos are fixed at this width regardless of geometry.
  localparam int POS_W = 10;

  // Scene sequencer states. Kept as plain constants so older
  // blocks that compare against raw bits keep working.
  localparam logic ST_PLAY = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  // Smallest r with 2**r >= n. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/demoscene_frame_engine_sync_delay_line.sv
// sync_delay_line: WIDTH-bit wide, DEPTH-stage shift register used to
// align timing flags with the external pixel generator's latency.
//   clk   in   pixel clock
//   rst_n in   synchronous active-low reset, clears every stage
//   din   in   WIDTH  flags entering the line
//   dout  out  WIDTH  flags delayed by DEPTH cycles (DEPTH=0: din itself)
module sync_delay_line
  import demoscene_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/demoscene_frame_engine.sv
// demoscene_frame_engine: parametrised VGA timing generator with sync
// re-alignment to an external pixel pipeline, a frame counter and a
// frame-synchronous scene sequencer (auto-advance, hold, skip).
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset
//   hold         in   level, freezes the per-scene frame counter
//   skip         in   pulse, requests an advance at a frame end
//   pix_r/g/b    in   COLOR_W colour, valid PIPE_DEPTH cycles after hpos/vpos
//   hpos, vpos   out  10-bit raw counters (combinational)
//   display_on   out  current position visible (undelayed)
//   frame_start  out  hpos==0 && vpos==0
//   frame_count  out  FRAME_W completed frames, wrapping
//   scene_idx    out  active scene
//   scene_start  out  one-cycle pulse on scene change (with frame_start)
//   vga_r/g/b    out  registered colour, blanked outside the visible area
//   hsync, vsync out  registered syncs aligned with vga_*
module demoscene_frame_engine
  import demoscene_pkg::*;
#(
  parameter int   H_VIS        = DEF_H_VIS,
  parameter int   H_FP         = DEF_H_FP,
  parameter int   H_SYNC       = DEF_H_SYNC,
  parameter int   H_BP         = DEF_H_BP,
  parameter int   V_VIS        = DEF_V_VIS,
  parameter int   V_FP         = DEF_V_FP,
  parameter int   V_SYNC       = DEF_V_SYNC,
  parameter int   V_BP         = DEF_V_BP,
  parameter logic SYNC_POL     = 1'b0,
  parameter int   COLOR_W      = 2,
  parameter int   PIPE_DEPTH   = 1,
  parameter int   NUM_SCENES   = 4,
  parameter int   SCENE_FRAMES = 256,
  parameter int   FRAME_W      = 16,
  localparam int  SCENE_W      = (clog2(NUM_SCENES) < 1) ? 1 : clog2(NUM_SCENES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               skip,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               display_on,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic [SCENE_W-1:0] scene_idx,
  output logic               scene_start,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               hsync,
  output logic               vsync
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int SCN_CNT_W = (clog2(SCENE_FRAMES) < 1) ? 1 : clog2(SCENE_FRAMES);

  if (H_TOT > (1 << POS_W)) begin : g_h_too_big
    $error("demoscene_frame_engine: H_TOT exceeds 1024");
  end
  if (V_TOT > (1 << POS_W)) begin : g_v_too_big
    $error("demoscene_frame_engine: V_TOT exceeds 1024");
  end
  if (PIPE_DEPTH < 0 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("demoscene_frame_engine: PIPE_DEPTH must be 0..8");
  end
  if (SCENE_FRAMES < 1) begin : g_bad_scene_frames
    $error("demoscene_frame_engine: SCENE_FRAMES must be at least 1");
  end

  // Window bounds are compared one bit wider so a sync pulse that runs
  // to the very end of a 1024-wide line does not wrap to 0.
  localparam int XW = POS_W + 1;
  localparam logic [XW-1:0] H_VIS_X = XW'(H_VIS);
  localparam logic [XW-1:0] H_SS_X  = XW'(H_VIS + H_FP);
  localparam logic [XW-1:0] H_SE_X  = XW'(H_VIS + H_FP + H_SYNC);
  localparam logic [XW-1:0] V_VIS_X = XW'(V_VIS);
  localparam logic [XW-1:0] V_SS_X  = XW'(V_VIS + V_FP);
  localparam logic [XW-1:0] V_SE_X  = XW'(V_VIS + V_FP + V_SYNC);
  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOT - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOT - 1);
  localparam logic [SCN_CNT_W-1:0] SCN_LAST   = SCN_CNT_W'(SCENE_FRAMES - 1);
  localparam logic [SCENE_W-1:0]   SCENE_LAST = SCENE_W'(NUM_SCENES - 1);

  logic [POS_W-1:0] h, v;
  logic [XW-1:0]    h_x, v_x;
  logic             h_last, v_last, frame_end;
  logic             hs_raw, vs_raw;
  logic [2:0]       align_dly;
  logic             de_dly, hs_dly, vs_dly;

  logic                 state;
  logic [SCN_CNT_W-1:0] scn_cnt;
  logic                 skip_pend;
  logic                 advance;

  // ---- stage 0: raw position counters and decoded flags ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + POS_W'(1);
    end else begin
      h <= h + POS_W'(1);
    end
  end

  assign h_x       = {1'b0, h};
  assign v_x       = {1'b0, v};
  assign h_last    = (h == H_LAST);
  assign v_last    = (v == V_LAST);
  assign frame_end = h_last && v_last;

  assign hpos        = h;
  assign vpos        = v;
  assign display_on  = (h_x < H_VIS_X) && (v_x < V_VIS_X);
  assign frame_start = (h == '0) && (v == '0);
  assign hs_raw      = (h_x >= H_SS_X) && (h_x < H_SE_X);
  assign vs_raw      = (v_x >= V_SS_X) && (v_x < V_SE_X);

  // ---- stages 1..PIPE_DEPTH: flags travel alongside the pixel pipeline ----
  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DEPTH)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({display_on, hs_raw, vs_raw}),
    .dout  (align_dly)
  );

  assign {de_dly, hs_dly, vs_dly} = align_dly;

  // ---- output stage: blank colour and drive sync levels ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else begin
      vga_r <= de_dly ? pix_r : '0;
      vga_g <= de_dly ? pix_g : '0;
      vga_b <= de_dly ? pix_b : '0;
      hsync <= hs_dly ? SYNC_POL : ~SYNC_POL;
      vsync <= vs_dly ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_count <= '0;
    else if (frame_end) frame_count <= frame_count + FRAME_W'(1);
  end

  // Expiry and a pending skip in the same frame collapse into one advance.
  // A skip arriving on the frame-end cycle itself is not yet in skip_pend,
  // so it lands in the following frame.
  assign advance = frame_end &&
                   (skip_pend || ((state == ST_PLAY) && (scn_cnt == SCN_LAST)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_PLAY;
      scn_cnt     <= '0;
      skip_pend   <= 1'b0;
      scene_idx   <= '0;
      scene_start <= 1'b0;
    end else begin
      state       <= hold ? ST_HOLD : ST_PLAY;
      scene_start <= advance;
      skip_pend   <= frame_end ? skip : (skip_pend | skip);
      if (advance) begin
        scn_cnt   <= '0;
        scene_idx <= (scene_idx == SCENE_LAST) ? '0 : scene_idx + SCENE_W'(1);
      end else if (frame_end && (state == ST_PLAY)) begin
        scn_cnt <= scn_cnt + SCN_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demoscene_frame_engine.sv
module tb_demoscene_frame_engine;

  localparam int HV = 4, HF = 1, HS = 2, HB = 1;
  localparam int VV = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FC = HT * VT;
  localparam int NS = 2;
  localparam int SF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, hold = 1'b0, skip = 1'b0;
  logic [1:0] pix_r0 = '0, pix_r3 = '0, pix_g = '0, pix_b = '0;

  logic [9:0]  hpos0, vpos0, hpos3, vpos3;
  logic        display_on0, frame_start0, scene_start0, hsync0, vsync0;
  logic        display_on3, frame_start3, scene_start3, hsync3, vsync3;
  logic [15:0] frame_count0, frame_count3;
  logic [0:0]  scene_idx0, scene_idx3;
  logic [1:0]  vga_r0, vga_g0, vga_b0, vga_r3, vga_g3, vga_b3;

  demoscene_frame_engine #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_W(2), .PIPE_DEPTH(0),
    .NUM_SCENES(NS), .SCENE_FRAMES(SF), .FRAME_W(16)
  ) u_dut_p0 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .skip(skip),
    .pix_r(pix_r0), .pix_g(pix_g), .pix_b(pix_b),
    .hpos(hpos0), .vpos(vpos0), .display_on(display_on0), .frame_start(frame_start0),
    .frame_count(frame_count0), .scene_idx(scene_idx0), .scene_start(scene_start0),
    .vga_r(vga_r0), .vga_g(vga_g0), .vga_b(vga_b0), .hsync(hsync0), .vsync(vsync0)
  );

  demoscene_frame_engine #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_W(2), .PIPE_DEPTH(3),
    .NUM_SCENES(NS), .SCENE_FRAMES(SF), .FRAME_W(16)
  ) u_dut_p3 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .skip(skip),
    .pix_r(pix_r3), .pix_g(pix_g), .pix_b(pix_b),
    .hpos(hpos3), .vpos(vpos3), .display_on(display_on3), .frame_start(frame_start3),
    .frame_count(frame_count3), .scene_idx(scene_idx3), .scene_start(scene_start3),
    .vga_r(vga_r3), .vga_g(vga_g3), .vga_b(vga_b3), .hsync(hsync3), .vsync(vsync3)
  );

  logic [29:0] obs_tim0, obs_tim3, e_tim0, e_tim3;
  logic [17:0] obs_scn0, obs_scn3, e_scn;
  assign obs_tim0 = {hpos0, vpos0, display_on0, frame_start0, hsync0, vsync0, vga_r0, vga_g0, vga_b0};
  assign obs_tim3 = {hpos3, vpos3, display_on3, frame_start3, hsync3, vsync3, vga_r3, vga_g3, vga_b3};
  assign obs_scn0 = {frame_count0, scene_idx0, scene_start0};
  assign obs_scn3 = {frame_count3, scene_idx3, scene_start3};

  int total = 0;
  int bad   = 0;

  // Reference model: mt counts cycles since reset, so the raster position
  // is just mt split by the line and frame lengths. Scene state is kept as
  // per-frame bookkeeping.
  int mt = 0;
  int m_scene = 0, m_cnt = 0;
  bit m_pend = 0, m_in_hold = 0, m_start = 0;

  function automatic bit m_vis(input int m);
    return (m >= 0) && ((m % HT) < HV) && (((m / HT) % VT) < VV);
  endfunction
  function automatic bit m_hs(input int m);
    return (m >= 0) && ((m % HT) >= HV + HF) && ((m % HT) < HV + HF + HS);
  endfunction
  function automatic bit m_vs(input int m);
    return (m >= 0) && (((m / HT) % VT) >= VV + VF) && (((m / HT) % VT) < VV + VF + VS);
  endfunction

  // pos: position the counters now show; src: position whose flags and
  // colour are now on the pins (negative = nothing has reached them yet).
  function automatic logic [29:0] exp_tim(input int pos, input int src,
                                          input logic [1:0] g, input logic [1:0] b);
    bit de;
    logic [1:0] r;
    de = m_vis(src);
    r  = de ? 2'(src % HT) : 2'd0;
    return {10'(pos % HT), 10'((pos / HT) % VT), m_vis(pos), ((pos % FC) == 0),
            m_hs(src) ? 1'b0 : 1'b1, m_vs(src) ? 1'b0 : 1'b1,
            r, de ? g : 2'd0, de ? b : 2'd0};
  endfunction

  task automatic tick();
    int c;
    bit fe, adv;
    logic [1:0] g, b;
    c = mt;
    pix_r0 = 2'(c % HT);
    pix_r3 = (c >= 3) ? 2'((c - 3) % HT) : 2'd0;
    g = 2'($urandom);
    b = 2'($urandom);
    pix_g = g;
    pix_b = b;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mt = 0; m_scene = 0; m_cnt = 0; m_pend = 0; m_in_hold = 0; m_start = 0;
      e_tim0 = exp_tim(0, -1, g, b);
      e_tim3 = exp_tim(0, -1, g, b);
    end else begin
      fe  = (c % FC) == FC - 1;
      adv = fe && (m_pend || (!m_in_hold && m_cnt == SF - 1));
      m_start = adv;
      if (adv) begin
        m_scene = (m_scene + 1) % NS;
        m_cnt   = 0;
      end else if (fe && !m_in_hold) begin
        m_cnt++;
      end
      m_pend    = fe ? skip : (m_pend || skip);
      m_in_hold = hold;
      mt = c + 1;
      e_tim0 = exp_tim(mt, c, g, b);
      e_tim3 = exp_tim(mt, c - 3, g, b);
    end
    e_scn = {16'(mt / FC), 1'(m_scene), m_start};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; skip = 1'b0;
    tick();
    tick();
    total++;
    if (obs_tim0 !== {20'd0, 4'b1111, 6'd0}) begin
      bad++; $display("FAIL reset_timing_p0 got=%h want=%h", obs_tim0, {20'd0, 4'b1111, 6'd0});
    end
    total++;
    if (obs_tim3 !== {20'd0, 4'b1111, 6'd0}) begin
      bad++; $display("FAIL reset_timing_p3 got=%h want=%h", obs_tim3, {20'd0, 4'b1111, 6'd0});
    end
    total++;
    if (obs_scn0 !== 18'd0) begin
      bad++; $display("FAIL reset_scene_p0 got=%h want=0", obs_scn0);
    end
    total++;
    if (obs_scn3 !== 18'd0) begin
      bad++; $display("FAIL reset_scene_p3 got=%h want=0", obs_scn3);
    end
  endtask

  task automatic test_timing();
    int t_h5_0, t_hs_0, t_h5_3, t_hs_3;
    t_h5_0 = -1; t_hs_0 = -1; t_h5_3 = -1; t_hs_3 = -1;
    rst_n = 1'b1;
    for (int i = 1; i <= 2 * FC + 8; i++) begin
      tick();
      total++;
      if (obs_tim0 !== e_tim0) begin
        bad++; $display("FAIL timing_p0 mt=%0d got=%h want=%h", mt, obs_tim0, e_tim0);
      end
      total++;
      if (obs_tim3 !== e_tim3) begin
        bad++; $display("FAIL timing_p3 mt=%0d got=%h want=%h", mt, obs_tim3, e_tim3);
      end
      if (mt == FC) begin
        total++;
        if (frame_count0 !== 16'd1) begin
          bad++; $display("FAIL frame_count_one got=%0d want=1", frame_count0);
        end
      end
      if (t_h5_0 < 0 && hpos0 === 10'd5) t_h5_0 = i;
      if (t_hs_0 < 0 && hsync0 === 1'b0) t_hs_0 = i;
      if (t_h5_3 < 0 && hpos3 === 10'd5) t_h5_3 = i;
      if (t_hs_3 < 0 && hsync3 === 1'b0) t_hs_3 = i;
    end
    total++;
    if (t_h5_0 < 0 || t_hs_0 < 0 || t_hs_0 - t_h5_0 != 1) begin
      bad++; $display("FAIL hsync_lag_p0 got=%0d want=1", t_hs_0 - t_h5_0);
    end
    total++;
    if (t_h5_3 < 0 || t_hs_3 < 0 || t_hs_3 - t_h5_3 != 4) begin
      bad++; $display("FAIL hsync_lag_p3 got=%0d want=4", t_hs_3 - t_h5_3);
    end
  endtask

  task automatic test_scene_auto();
    int pulses, t1, t2;
    pulses = 0; t1 = -1; t2 = -1;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 6 * FC; i++) begin
      tick();
      total++;
      if (obs_scn0 !== e_scn) begin
        bad++; $display("FAIL scene_auto_p0 mt=%0d got=%h want=%h", mt, obs_scn0, e_scn);
      end
      total++;
      if (obs_scn3 !== e_scn) begin
        bad++; $display("FAIL scene_auto_p3 mt=%0d got=%h want=%h", mt, obs_scn3, e_scn);
      end
      if (scene_start0 === 1'b1) begin
        pulses++;
        if (t1 < 0) t1 = mt; else t2 = mt;
        total++;
        if (frame_start0 !== 1'b1) begin
          bad++; $display("FAIL scene_start_with_frame_start mt=%0d got=%b want=1", mt, frame_start0);
        end
      end
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("FAIL scene_pulse_count got=%0d want=2", pulses);
    end
    total++;
    if (t1 != 3 * FC || t2 != 6 * FC) begin
      bad++; $display("FAIL scene_change_times got=%0d,%0d want=%0d,%0d", t1, t2, 3 * FC, 6 * FC);
    end
    total++;
    if (scene_idx0 !== 1'b0) begin
      bad++; $display("FAIL scene_idx_after_six got=%0d want=0", scene_idx0);
    end
  endtask

  task automatic test_hold();
    int n;
    hold = 1'b1;
    for (int i = 0; i < 5 * FC; i++) begin
      tick();
      total++;
      if (obs_scn0 !== e_scn) begin
        bad++; $display("FAIL hold_p0 mt=%0d got=%h want=%h", mt, obs_scn0, e_scn);
      end
    end
    total++;
    if (scene_idx0 !== 1'b0) begin
      bad++; $display("FAIL hold_scene_frozen got=%0d want=0", scene_idx0);
    end
    hold = 1'b0;
    n = 0;
    while (scene_start0 !== 1'b1 && n < 10 * FC) begin
      tick();
      n++;
      total++;
      if (obs_scn3 !== e_scn) begin
        bad++; $display("FAIL hold_release_p3 mt=%0d got=%h want=%h", mt, obs_scn3, e_scn);
      end
    end
    total++;
    if (n != 3 * FC || scene_idx0 !== 1'b1) begin
      bad++; $display("FAIL hold_release_latency got=%0d scene=%0d want=%0d scene=1", n, scene_idx0, 3 * FC);
    end
  endtask

  task automatic test_skip();
    int n;
    // skip in the middle of a frame
    repeat (20) tick();
    skip = 1'b1; tick(); skip = 1'b0;
    n = 1;
    while (scene_start0 !== 1'b1 && n < 4 * FC) begin
      tick(); n++;
      total++;
      if (obs_scn0 !== e_scn) begin
        bad++; $display("FAIL skip_mid_p0 mt=%0d got=%h want=%h", mt, obs_scn0, e_scn);
      end
    end
    total++;
    if (n != FC - 20 || scene_idx0 !== 1'b0) begin
      bad++; $display("FAIL skip_mid_latency got=%0d scene=%0d want=%0d scene=0", n, scene_idx0, FC - 20);
    end
    // skip on the frame-end cycle itself
    repeat (FC - 1) tick();
    skip = 1'b1; tick(); skip = 1'b0;
    total++;
    if (scene_start0 !== 1'b0) begin
      bad++; $display("FAIL skip_frame_end_deferred got=%b want=0", scene_start0);
    end
    n = 0;
    while (scene_start0 !== 1'b1 && n < 4 * FC) begin
      tick(); n++;
      total++;
      if (obs_scn0 !== e_scn) begin
        bad++; $display("FAIL skip_end_p0 mt=%0d got=%h want=%h", mt, obs_scn0, e_scn);
      end
    end
    total++;
    if (n != FC || scene_idx0 !== 1'b1) begin
      bad++; $display("FAIL skip_end_latency got=%0d scene=%0d want=%0d scene=1", n, scene_idx0, FC);
    end
    // skip while held
    hold = 1'b1;
    repeat (10) tick();
    skip = 1'b1; tick(); skip = 1'b0;
    n = 1;
    while (scene_start0 !== 1'b1 && n < 4 * FC) begin
      tick(); n++;
      total++;
      if (obs_scn3 !== e_scn) begin
        bad++; $display("FAIL skip_hold_p3 mt=%0d got=%h want=%h", mt, obs_scn3, e_scn);
      end
    end
    total++;
    if (n != FC - 10 || scene_idx0 !== 1'b0) begin
      bad++; $display("FAIL skip_hold_latency got=%0d scene=%0d want=%0d scene=0", n, scene_idx0, FC - 10);
    end
    hold = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20 * FC; i++) begin
      if ($urandom_range(0, 63) == 0) hold = ~hold;
      skip = ($urandom_range(0, 49) == 0);
      tick();
      total++;
      if (obs_tim0 !== e_tim0) begin
        bad++; $display("FAIL rand_timing_p0 mt=%0d got=%h want=%h", mt, obs_tim0, e_tim0);
      end
      total++;
      if (obs_tim3 !== e_tim3) begin
        bad++; $display("FAIL rand_timing_p3 mt=%0d got=%h want=%h", mt, obs_tim3, e_tim3);
      end
      total++;
      if (obs_scn0 !== e_scn || obs_scn3 !== e_scn) begin
        bad++; $display("FAIL rand_scene mt=%0d got=%h/%h want=%h", mt, obs_scn0, obs_scn3, e_scn);
      end
    end
    hold = 1'b0;
    skip = 1'b0;
  endtask

  task automatic test_reset_midscene();
    int n;
    n = 0;
    while (m_scene != 1 && n < 10 * FC) begin tick(); n++; end
    while ((mt % HT) != 3 && n < 10 * FC) begin tick(); n++; end
    total++;
    if (scene_idx0 !== 1'b1 || hpos0 !== 10'd3) begin
      bad++; $display("FAIL midscene_setup scene=%0d hpos=%0d want scene=1 hpos=3", scene_idx0, hpos0);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    total++;
    if (obs_tim0 !== {20'd0, 4'b1111, 6'd0} || obs_tim3 !== {20'd0, 4'b1111, 6'd0}) begin
      bad++; $display("FAIL midscene_reset_timing got=%h/%h want=%h", obs_tim0, obs_tim3, {20'd0, 4'b1111, 6'd0});
    end
    total++;
    if (obs_scn0 !== 18'd0 || obs_scn3 !== 18'd0) begin
      bad++; $display("FAIL midscene_reset_scene got=%h/%h want=0", obs_scn0, obs_scn3);
    end
    for (int i = 0; i < 2 * FC; i++) begin
      tick();
      total++;
      if (obs_tim3 !== e_tim3 || obs_scn3 !== e_scn) begin
        bad++; $display("FAIL post_reset_p3 mt=%0d got=%h,%h want=%h,%h", mt, obs_tim3, obs_scn3, e_tim3, e_scn);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_scene_auto();
    test_hold();
    test_skip();
    test_random();
    test_reset_midscene();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
